// File: rtl/plc_sched_pkg.sv
// plc_sched_pkg
//   Shared definitions for the PLC checker scheduler: the two-state FSM
//   encoding and the default sizing used by plc_check_sched.
package plc_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   localparam int unsigned DEF_PERIOD_W     = 16;
   localparam int unsigned DEF_STARVE_LIMIT = 8;
   localparam int unsigned DEF_STARVE_W     = 4;
   localparam int unsigned DEF_TIMEOUT      = 1024;
   localparam int unsigned DEF_TIMEOUT_W    = 11;
   localparam int unsigned DEF_STAT_W       = 16;

endpackage

// File: rtl/plc_interval_timer.sv
// plc_interval_timer
//   Free-running interval counter for periodic check triggering.
//   Counts while en_i is high, emits a one-cycle tick_o (combinational) in the
//   cycle the count reaches period_i-1 and wraps to zero on that tick.
//   Holds its value while en_i is low; clr_i forces the count to zero and has
//   priority over counting. period_i == 0 never ticks.
// Ports
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   en_i      in   count enable
//   clr_i     in   synchronous clear
//   period_i  in   [W] interval length in cycles
//   tick_o    out  terminal-count pulse
module plc_interval_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] period_i,
   output logic         tick_o
);

   logic [W-1:0] count_q, count_d;

   // ">=" rather than "==" so a period shortened below the current count
   // still terminates instead of running the full counter range.
   assign tick_o = en_i && (period_i != '0) && (count_q >= (period_i - 1'b1));

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (period_i != '0)) begin
         count_d = tick_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/plc_check_sched.sv
// plc_check_sched
//   Scheduler/arbiter for the PLC checker. Launches list checks (periodic via
//   plc_interval_timer, or forced), shares the dcache read port between core
//   traffic and checker reads, bounds checker starvation with a one-cycle core
//   stall, and aborts checks that run too long.
//   Optional build macro PLC_SCHED_STATS_EN adds saturating statistics outputs
//   stat_checks / stat_forced_stalls / stat_timeouts.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   sched_en        enable periodic triggering
//   period_cfg      [PERIOD_W] cycles between periodic checks, 0 = off
//   force_check     request an immediate check
//   list_nonempty   PLC list holds at least one entry
//   chk_done        checker finished the last tuple
//   chk_rd_req      checker wants the read port
//   core_rd_en/wr_en core cache access this cycle
//   err_clr         clears timeout_err
//   chk_start       one-cycle start pulse (registered)
//   chk_abort       one-cycle abort pulse on timeout (registered)
//   chk_rd_gnt      read port granted to checker (combinational)
//   mux_sel_chk     read-port mux select, equals chk_rd_gnt
//   core_stall      registered one-cycle core stall
//   busy            a check is running
//   timeout_err     sticky timeout flag
module plc_check_sched
   import plc_sched_pkg::*;
#(
   parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned STARVE_W     = DEF_STARVE_W,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
   parameter int unsigned TIMEOUT_W    = DEF_TIMEOUT_W
`ifdef PLC_SCHED_STATS_EN
   ,
   parameter int unsigned STAT_W       = DEF_STAT_W
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sched_en,
   input  logic [PERIOD_W-1:0] period_cfg,
   input  logic                force_check,
   input  logic                list_nonempty,
   input  logic                chk_done,
   input  logic                chk_rd_req,
   input  logic                core_rd_en,
   input  logic                core_wr_en,
   input  logic                err_clr,
   output logic                chk_start,
   output logic                chk_abort,
   output logic                chk_rd_gnt,
   output logic                mux_sel_chk,
   output logic                core_stall,
   output logic                busy,
   output logic                timeout_err
`ifdef PLC_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0]   stat_checks,
   output logic [STAT_W-1:0]   stat_forced_stalls,
   output logic [STAT_W-1:0]   stat_timeouts
`endif
);

   localparam logic [STARVE_W-1:0]  STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
   localparam logic [TIMEOUT_W-1:0] RUN_LAST    = TIMEOUT_W'(TIMEOUT - 1);

   sched_state_e         state_q, state_d;
   logic                 pending_q, pending_d;
   logic                 chk_start_q, chk_start_d;
   logic                 chk_abort_q, chk_abort_d;
   logic                 core_stall_q, core_stall_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [STARVE_W-1:0]  starve_q, starve_d;
   logic [TIMEOUT_W-1:0] run_q, run_d;

   logic in_run;
   logic core_busy;
   logic timer_en;
   logic timer_clr;
   logic timer_tick;
   logic done_hit;
   logic timeout_hit;

   assign in_run      = (state_q == RUN);
   assign core_busy   = core_rd_en | core_wr_en;
   assign done_hit    = in_run && chk_done;
   // chk_done in the timeout cycle wins: the check ends normally.
   assign timeout_hit = in_run && !chk_done && (run_q == RUN_LAST);

   // Timer only advances in IDLE; a dropped request (empty list) restarts it.
   assign timer_en  = !in_run && sched_en && (period_cfg != '0);
   assign timer_clr = !in_run && pending_q && !list_nonempty;

   plc_interval_timer #(
      .W (PERIOD_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .en_i     (timer_en),
      .clr_i    (timer_clr),
      .period_i (period_cfg),
      .tick_o   (timer_tick)
   );

   // During a forced stall the core is held off, so the checker may go.
   assign chk_rd_gnt  = in_run && chk_rd_req && (!core_busy || core_stall_q);
   assign mux_sel_chk = chk_rd_gnt;

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q | force_check | timer_tick;
      chk_start_d   = 1'b0;
      chk_abort_d   = 1'b0;
      core_stall_d  = 1'b0;
      timeout_err_d = timeout_err_q && !err_clr;
      starve_d      = starve_q;
      run_d         = run_q;

      unique case (state_q)
         IDLE: begin
            starve_d = '0;
            run_d    = '0;
            // Any request consumed here (launched or dropped) also absorbs
            // requests arriving in the same cycle.
            if (pending_q) begin
               pending_d = 1'b0;
               if (list_nonempty) begin
                  chk_start_d = 1'b1;
                  state_d     = RUN;
               end
            end
         end
         RUN: begin
            run_d = run_q + 1'b1;
            if (done_hit) begin
               state_d  = IDLE;
               run_d    = '0;
               starve_d = '0;
            end else if (timeout_hit) begin
               state_d       = IDLE;
               chk_abort_d   = 1'b1;
               timeout_err_d = 1'b1;
               pending_d     = 1'b0;
               run_d         = '0;
               starve_d      = '0;
            end else if (chk_rd_gnt) begin
               starve_d = '0;
            end else if (chk_rd_req && core_busy && !core_stall_q) begin
               // The last denial arms the stall for the following cycle.
               if (starve_q == STARVE_LAST) begin
                  starve_d     = '0;
                  core_stall_d = 1'b1;
               end else begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pending_q     <= 1'b0;
         chk_start_q   <= 1'b0;
         chk_abort_q   <= 1'b0;
         core_stall_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         starve_q      <= '0;
         run_q         <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         chk_start_q   <= chk_start_d;
         chk_abort_q   <= chk_abort_d;
         core_stall_q  <= core_stall_d;
         timeout_err_q <= timeout_err_d;
         starve_q      <= starve_d;
         run_q         <= run_d;
      end
   end

   assign chk_start   = chk_start_q;
   assign chk_abort   = chk_abort_q;
   assign core_stall  = core_stall_q;
   assign busy        = in_run;
   assign timeout_err = timeout_err_q;

`ifdef PLC_SCHED_STATS_EN
   // Index 0: completed checks, 1: stall cycles, 2: aborts.
   logic [2:0] stat_inc;
   assign stat_inc[0] = done_hit;
   assign stat_inc[1] = core_stall_q;
   assign stat_inc[2] = timeout_hit;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stat
         logic [STAT_W-1:0] cnt_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else if (stat_inc[gi] && (cnt_q != '1)) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   endgenerate

   assign stat_checks        = g_stat[0].cnt_q;
   assign stat_forced_stalls = g_stat[1].cnt_q;
   assign stat_timeouts      = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_plc_check_sched.sv
// tb_plc_check_sched
//   Scenario-driven bench for plc_check_sched (STARVE_LIMIT=8, TIMEOUT=16).
//   Expected event cycles are queued when stimulus is applied and popped as
//   each cycle is examined.
module tb_plc_check_sched;

   localparam int PERIOD_W = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                sched_en;
   logic [PERIOD_W-1:0] period_cfg;
   logic                force_check;
   logic                list_nonempty;
   logic                chk_done;
   logic                chk_rd_req;
   logic                core_rd_en;
   logic                core_wr_en;
   logic                err_clr;
   logic                chk_start;
   logic                chk_abort;
   logic                chk_rd_gnt;
   logic                mux_sel_chk;
   logic                core_stall;
   logic                busy;
   logic                timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int start_q[$];
   int abort_q[$];
   int stall_q[$];
   int gnt_q[$];

   plc_check_sched #(
      .PERIOD_W     (PERIOD_W),
      .STARVE_LIMIT (8),
      .STARVE_W     (4),
      .TIMEOUT      (16),
      .TIMEOUT_W    (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sched_en      (sched_en),
      .period_cfg    (period_cfg),
      .force_check   (force_check),
      .list_nonempty (list_nonempty),
      .chk_done      (chk_done),
      .chk_rd_req    (chk_rd_req),
      .core_rd_en    (core_rd_en),
      .core_wr_en    (core_wr_en),
      .err_clr       (err_clr),
      .chk_start     (chk_start),
      .chk_abort     (chk_abort),
      .chk_rd_gnt    (chk_rd_gnt),
      .mux_sel_chk   (mux_sel_chk),
      .core_stall    (core_stall),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d required=finish", cyc);
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      sched_en      = 1'b0;
      period_cfg    = '0;
      force_check   = 1'b0;
      list_nonempty = 1'b0;
      chk_done      = 1'b0;
      chk_rd_req    = 1'b0;
      core_rd_en    = 1'b0;
      core_wr_en    = 1'b0;
      err_clr       = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      start_q.delete();
      abort_q.delete();
      stall_q.delete();
      gnt_q.delete();
   endtask

   task automatic test_reset();
      logic [6:0] got;
      do_reset();
      got = {chk_start, chk_abort, chk_rd_gnt, mux_sel_chk, core_stall, busy, timeout_err};
      n_assert++;
      if (got !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b required=0000000", got);
      end
      $display("reset: outputs=%b", got);
   endtask

   // period 10, chk_done held high: each check lasts one RUN cycle, so starts
   // are 11 cycles apart (10 IDLE cycles each).
   task automatic test_periodic();
      bit exp_s;
      int c0;
      do_reset();
      c0 = cyc;
      sched_en = 1'b1; period_cfg = 16'd10; list_nonempty = 1'b1; chk_done = 1'b1;
      start_q.push_back(c0 + 11);
      start_q.push_back(c0 + 22);
      start_q.push_back(c0 + 33);
      for (int k = 1; k <= 34; k++) begin
         tick();
         exp_s = (start_q.size() > 0) && (start_q[0] == cyc);
         if (exp_s) void'(start_q.pop_front());
         n_assert++;
         if (chk_start !== exp_s) begin
            n_fail++;
            $display("FAIL periodic_start cyc=%0d got=%b required=%b", cyc - c0, chk_start, exp_s);
         end
         if (exp_s) $display("periodic: chk_start at +%0d", cyc - c0);
      end
      n_assert++;
      if (start_q.size() != 0) begin
         n_fail++;
         $display("FAIL periodic_missing got=%0d required=0 outstanding", start_q.size());
      end
   endtask

   // Two force pulses during RUN merge into one follow-up check, started two
   // cycles after chk_done.
   task automatic test_force_during_run();
      bit exp_s, exp_b;
      int c0;
      do_reset();
      c0 = cyc;
      list_nonempty = 1'b1;
      force_check = 1'b1;
      start_q.push_back(c0 + 2);
      start_q.push_back(c0 + 8);
      for (int k = 1; k <= 12; k++) begin
         tick();
         force_check = (k == 3 || k == 4);
         chk_done    = (k == 6 || k == 8);
         exp_b = (k >= 2 && k <= 6) || (k == 8);
         exp_s = (start_q.size() > 0) && (start_q[0] == cyc);
         if (exp_s) void'(start_q.pop_front());
         n_assert++;
         if (chk_start !== exp_s) begin
            n_fail++;
            $display("FAIL force_start cyc=+%0d got=%b required=%b", k, chk_start, exp_s);
         end
         n_assert++;
         if (busy !== exp_b) begin
            n_fail++;
            $display("FAIL force_busy cyc=+%0d got=%b required=%b", k, busy, exp_b);
         end
         if (exp_s) $display("force: chk_start at +%0d", k);
      end
      n_assert++;
      if (start_q.size() != 0) begin
         n_fail++;
         $display("FAIL force_missing got=%0d required=0 outstanding", start_q.size());
      end
   endtask

   // Forced request with an empty list is dropped and restarts the timer.
   task automatic test_empty_list();
      bit exp_s;
      int c0;
      do_reset();
      c0 = cyc;
      sched_en = 1'b1; period_cfg = 16'd10; chk_done = 1'b1;
      start_q.push_back(c0 + 18);
      for (int k = 1; k <= 22; k++) begin
         tick();
         force_check = (k == 5);
         if (k == 7) list_nonempty = 1'b1;
         exp_s = (start_q.size() > 0) && (start_q[0] == cyc);
         if (exp_s) void'(start_q.pop_front());
         n_assert++;
         if (chk_start !== exp_s) begin
            n_fail++;
            $display("FAIL empty_start cyc=+%0d got=%b required=%b", k, chk_start, exp_s);
         end
         if (exp_s) $display("empty: chk_start at +%0d", k);
      end
      n_assert++;
      if (start_q.size() != 0) begin
         n_fail++;
         $display("FAIL empty_missing got=%0d required=0 outstanding", start_q.size());
      end
   endtask

   // Check 1: read traffic held, stall+grant on RUN cycle 9.
   // Check 2: write traffic, a free cycle at RUN cycle 6 resets starvation,
   // so the stall lands on RUN cycle 15.
   task automatic test_starvation();
      bit exp_st, exp_g;
      int c0;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         c0 = cyc;
         list_nonempty = 1'b1;
         force_check = 1'b1;
         chk_rd_req = 1'b1;
         core_rd_en = (pass == 0);
         core_wr_en = (pass == 1);
         if (pass == 0) begin
            stall_q.push_back(c0 + 10);
            gnt_q.push_back(c0 + 10);
         end else begin
            gnt_q.push_back(c0 + 7);
            stall_q.push_back(c0 + 16);
            gnt_q.push_back(c0 + 16);
         end
         for (int k = 1; k <= 16; k++) begin
            tick();
            force_check = 1'b0;
            if (pass == 1) core_wr_en = (k != 7);
            chk_done = (k == 16);
            #1;
            exp_st = (stall_q.size() > 0) && (stall_q[0] == cyc);
            if (exp_st) void'(stall_q.pop_front());
            exp_g = (gnt_q.size() > 0) && (gnt_q[0] == cyc);
            if (exp_g) void'(gnt_q.pop_front());
            n_assert++;
            if (core_stall !== exp_st) begin
               n_fail++;
               $display("FAIL starve_stall pass=%0d cyc=+%0d got=%b required=%b", pass, k, core_stall, exp_st);
            end
            n_assert++;
            if (chk_rd_gnt !== exp_g || mux_sel_chk !== exp_g) begin
               n_fail++;
               $display("FAIL starve_gnt pass=%0d cyc=+%0d got=%b/%b required=%b", pass, k, chk_rd_gnt, mux_sel_chk, exp_g);
            end
            if (exp_st || exp_g) $display("starve: pass %0d gnt=%b stall=%b at +%0d", pass, chk_rd_gnt, core_stall, k);
         end
         tick();
         chk_done = 1'b0;
         #1;
         n_assert++;
         if (busy !== 1'b0 || chk_rd_gnt !== 1'b0 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_idle pass=%0d got busy=%b gnt=%b stall=%b required=0", pass, busy, chk_rd_gnt, core_stall);
         end
      end
   endtask

   // Hung check: abort 16 cycles after start, sticky error, clear, then a
   // second timeout with err_clr in the setting cycle and a pending force
   // that the abort must discard.
   task automatic test_watchdog();
      bit exp_a, exp_b, exp_e, exp_s;
      int c0;
      do_reset();
      c0 = cyc;
      list_nonempty = 1'b1;
      force_check = 1'b1;
      abort_q.push_back(c0 + 18);
      for (int k = 1; k <= 22; k++) begin
         tick();
         force_check = 1'b0;
         err_clr = (k == 20);
         exp_a = (abort_q.size() > 0) && (abort_q[0] == cyc);
         if (exp_a) void'(abort_q.pop_front());
         exp_b = (k >= 2 && k <= 17);
         exp_e = (k >= 18 && k <= 20);
         n_assert++;
         if (chk_abort !== exp_a) begin
            n_fail++;
            $display("FAIL wd_abort cyc=+%0d got=%b required=%b", k, chk_abort, exp_a);
         end
         n_assert++;
         if (busy !== exp_b || timeout_err !== exp_e) begin
            n_fail++;
            $display("FAIL wd_state cyc=+%0d got busy=%b err=%b required busy=%b err=%b", k, busy, timeout_err, exp_b, exp_e);
         end
         if (exp_a) $display("watchdog: chk_abort at +%0d err=%b", k, timeout_err);
      end
      err_clr = 1'b0;
      c0 = cyc;
      force_check = 1'b1;
      abort_q.push_back(c0 + 18);
      start_q.push_back(c0 + 2);
      for (int k = 1; k <= 22; k++) begin
         tick();
         force_check = (k == 5);
         err_clr = (k == 17);
         exp_a = (abort_q.size() > 0) && (abort_q[0] == cyc);
         if (exp_a) void'(abort_q.pop_front());
         exp_s = (start_q.size() > 0) && (start_q[0] == cyc);
         if (exp_s) void'(start_q.pop_front());
         exp_e = (k >= 18);
         n_assert++;
         if (chk_abort !== exp_a || chk_start !== exp_s) begin
            n_fail++;
            $display("FAIL wd2_pulses cyc=+%0d got abort=%b start=%b required abort=%b start=%b", k, chk_abort, chk_start, exp_a, exp_s);
         end
         n_assert++;
         if (timeout_err !== exp_e) begin
            n_fail++;
            $display("FAIL wd2_err cyc=+%0d got=%b required=%b", k, timeout_err, exp_e);
         end
         if (exp_a) $display("watchdog2: chk_abort at +%0d err=%b", k, timeout_err);
      end
      err_clr = 1'b0;
   endtask

   // Reset during RUN with checker traffic active; timeout_err is still set
   // from the previous scenario.
   task automatic test_rst_mid_run();
      logic [6:0] got;
      int c0;
      c0 = cyc;
      force_check = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         force_check = 1'b0;
         chk_rd_req = (k >= 3);
         core_rd_en = (k >= 3);
         if (k == 5) rst = 1'b1;
      end
      n_assert++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_busy got=%b required=1", busy);
      end
      tick();
      rst = 1'b0;
      #1;
      got = {chk_start, chk_abort, chk_rd_gnt, mux_sel_chk, core_stall, busy, timeout_err};
      n_assert++;
      if (got !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_mid_run got=%b required=0000000", got);
      end
      $display("rst_mid_run: outputs=%b", got);
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_assert++;
         if (chk_abort !== 1'b0 || busy !== 1'b0 || chk_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after cyc=+%0d got abort=%b busy=%b start=%b required=0", k, chk_abort, busy, chk_start);
         end
      end
      chk_rd_req = 1'b0;
      core_rd_en = 1'b0;
   endtask

   // chk_done lands in the timeout cycle: normal completion, no abort.
   task automatic test_done_at_timeout();
      bit exp_b;
      int c0;
      do_reset();
      c0 = cyc;
      list_nonempty = 1'b1;
      force_check = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         force_check = 1'b0;
         chk_done = (k == 17);
         exp_b = (k >= 2 && k <= 17);
         n_assert++;
         if (chk_abort !== 1'b0 || timeout_err !== 1'b0 || busy !== exp_b) begin
            n_fail++;
            $display("FAIL done_timeout cyc=+%0d got abort=%b err=%b busy=%b required abort=0 err=0 busy=%b", k, chk_abort, timeout_err, busy, exp_b);
         end
      end
      $display("done_at_timeout: busy=%b abort=%b err=%b", busy, chk_abort, timeout_err);
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_periodic();
      test_force_during_run();
      test_empty_list();
      test_starvation();
      test_watchdog();
      test_rst_mid_run();
      test_done_at_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
